// File: rtl/w0rm_mem_bus_pkg.sv
// W0RM memory bus shared definitions: FSM encoding, sizing helpers, tag layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package w0rm_mem_bus_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    RD_REQ  = S_RD_REQ,
    RD_WAIT = S_RD_WAIT,
    WR_REQ  = S_WR_REQ,
    WR_WAIT = S_WR_WAIT
  } state_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Address stride for one data word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Tag layout: MSB flags a write, the remaining low bits carry the word index.
  function automatic int tag_wr_bit(input int user_width);
    return user_width - 1;
  endfunction

  // Wait-timer counter must be able to hold TIMEOUT itself.
  function automatic int timer_width(input int timeout);
    return log2(timeout + 1);
  endfunction

endpackage

// File: rtl/w0rm_mem_copy_master_wait_timer.sv
// Wait-state watchdog: counts cycles spent waiting for a response.
// Latency: expire is combinational from the count; asserts on the TIMEOUT-th wait cycle.
// Backpressure: none; clear has priority over enable.
module w0rm_mem_wait_timer
  import w0rm_mem_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = timer_width(TIMEOUT);

  logic [TW-1:0] cnt;

  // Expiry fires in the wait cycle that would bring the count to TIMEOUT.
  assign expire = enable && (cnt == TW'(TIMEOUT - 1));

  // Count wait cycles; cleared on every request so each wait starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/w0rm_mem_copy_master.sv
// Block copy initiator: per word one tagged read, then one tagged write of the read data.
// Latency: 4 cycles per word with a 1-cycle responder; start to done = 4N+1 cycles.
// Backpressure: waits for a tag-matched response; aborts with error on mismatch or timeout.
module w0rm_mem_copy_master
  import w0rm_mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 15
) (
  input  logic                   mem_clk,
  input  logic                   mem_reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   mem_valid_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic [USER_WIDTH-1:0]  mem_user_o,
  input  logic                   mem_valid_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [USER_WIDTH-1:0]  mem_user_i
);

  localparam int                    WB     = tag_wr_bit(USER_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  src_ptr;
  logic [ADDR_WIDTH-1:0]  dst_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] index;
  logic [COUNT_WIDTH-1:0] index_nxt;
  logic [ADDR_WIDTH-1:0]  src_nxt;
  logic [ADDR_WIDTH-1:0]  dst_nxt;
  logic                   timer_clear;
  logic                   timer_en;
  logic                   timer_expire;

  // Tag = {write flag, index truncated/zero-extended into the low bits}.
  function automatic logic [USER_WIDTH-1:0] make_tag(input logic wr,
                                                      input logic [COUNT_WIDTH-1:0] idx);
    logic [WB-1:0] low;
    low = WB'(idx);
    return {wr, low};
  endfunction

  assign index_nxt = index + COUNT_WIDTH'(1);
  assign src_nxt   = src_ptr + STRIDE;
  assign dst_nxt   = dst_ptr + STRIDE;

  // Every request restarts the watchdog; it only runs while waiting.
  assign timer_clear = (state == RD_REQ) || (state == WR_REQ);
  assign timer_en    = (state == RD_WAIT) || (state == WR_WAIT);

  w0rm_mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (mem_clk),
    .reset  (mem_reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // Copy FSM with registered bus outputs; request fields are loaded on entry to a REQ state.
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      count_q     <= '0;
      index       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_user_o  <= '0;
    end else begin
      done_o      <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src_ptr <= src_addr_i;
            dst_ptr <= dst_addr_i;
            count_q <= count_i;
            index   <= '0;
            error_o <= 1'b0;
            if (count_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state       <= RD_REQ;
              busy_o      <= 1'b1;
              mem_valid_o <= 1'b1;
              mem_read_o  <= 1'b1;
              mem_addr_o  <= src_addr_i;
              mem_user_o  <= make_tag(1'b0, '0);
            end
          end
        end
        RD_REQ: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // A response on the expiry cycle still wins over the timeout.
          if (mem_valid_i && (mem_user_i == make_tag(1'b0, index))) begin
            state       <= WR_REQ;
            mem_valid_o <= 1'b1;
            mem_write_o <= 1'b1;
            mem_addr_o  <= dst_ptr;
            mem_data_o  <= mem_data_i;
            mem_user_o  <= make_tag(1'b1, index);
          end else if (mem_valid_i || timer_expire) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            error_o <= 1'b1;
          end
        end
        WR_REQ: begin
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_valid_i && (mem_user_i == make_tag(1'b1, index))) begin
            src_ptr <= src_nxt;
            dst_ptr <= dst_nxt;
            index   <= index_nxt;
            if (index_nxt == count_q) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state       <= RD_REQ;
              mem_valid_o <= 1'b1;
              mem_read_o  <= 1'b1;
              mem_addr_o  <= src_nxt;
              mem_user_o  <= make_tag(1'b0, index_nxt);
            end
          end else if (mem_valid_i || timer_expire) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            error_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w0rm_mem_copy_master.sv
// Testbench for w0rm_mem_copy_master: scoreboard of expected requests and done events
// produced by a word-by-word copy model, with a 1-cycle responder over a sparse memory.
module tb_w0rm_mem_copy_master;

  localparam int TIMEOUT = 15;

  logic        mem_clk;
  logic        mem_reset;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] count_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        mem_valid_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_user_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_user_i;

  w0rm_mem_copy_master #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .USER_WIDTH  (32),
    .COUNT_WIDTH (16),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .mem_clk     (mem_clk),
    .mem_reset   (mem_reset),
    .start_i     (start_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .count_i     (count_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .mem_valid_o (mem_valid_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_user_o  (mem_user_o),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .mem_user_i  (mem_user_i)
  );

  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] user;
  } req_t;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int vld_cnt = 0;
  int busy_cnt = 0;
  bit corrupt_rd = 1'b0;

  task automatic check(input string nm, input bit ok, input string det);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: %s", nm, det);
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return a[31:30] == 2'b01;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(posedge mem_clk) cyc <= cyc + 1;

  // Registered responder: answers mapped requests one cycle later, echoing the tag.
  always @(posedge mem_clk) begin
    mem_valid_i <= 1'b0;
    if (mem_valid_o && mapped(mem_addr_o)) begin
      mem_valid_i <= 1'b1;
      mem_user_i  <= (corrupt_rd && mem_read_o) ? (mem_user_o ^ 32'h1) : mem_user_o;
      if (mem_read_o) mem_data_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
      if (mem_write_o) mem[mem_addr_o] = mem_data_o;
    end
  end

  // Monitor: every request and done pulse must match the head of its queue.
  always @(negedge mem_clk) begin
    if (busy_o) busy_cnt++;
    if (mem_valid_o) begin
      vld_cnt++;
      if (req_q.size() == 0) begin
        check("unexpected_req", 1'b0, $sformatf("got rd=%0b wr=%0b addr=%h user=%h, required none",
              mem_read_o, mem_write_o, mem_addr_o, mem_user_o));
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("req", (mem_write_o == e.wr) && (mem_read_o == !e.wr) && (mem_addr_o == e.addr) &&
              (mem_user_o == e.user) && (!e.wr || (mem_data_o == e.data)),
              $sformatf("got wr=%0b rd=%0b addr=%h data=%h user=%h, required wr=%0b addr=%h data=%h user=%h",
              mem_write_o, mem_read_o, mem_addr_o, mem_data_o, mem_user_o, e.wr, e.addr, e.data, e.user));
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1'b0, $sformatf("got done at cycle %0d, required none", cyc));
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("done", (cyc == d.cyc) && (error_o == d.err),
              $sformatf("got cycle %0d error %0b, required cycle %0d error %0b", cyc, error_o, d.cyc, d.err));
      end
    end
  end

  // Reference model: sequential word copy over the reference memory, with cycle accounting.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit corrupt, input bit exp_done, input int c0);
    int    t;
    bit    err;
    req_t  r;
    done_t dn;
    t = 0;
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa;
      logic [31:0] da;
      logic [31:0] w;
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      r.wr = 1'b0; r.addr = sa; r.data = 32'h0; r.user = {1'b0, 31'(i)};
      req_q.push_back(r);
      if (!mapped(sa)) begin t += 1 + TIMEOUT; err = 1'b1; break; end
      if (corrupt) begin t += 2; err = 1'b1; break; end
      t += 2;
      w = ref_rd(sa);
      r.wr = 1'b1; r.addr = da; r.data = w; r.user = {1'b1, 31'(i)};
      req_q.push_back(r);
      if (!mapped(da)) begin t += 1 + TIMEOUT; err = 1'b1; break; end
      ref_mem[da] = w;
      t += 2;
    end
    dn.cyc = c0 + t + 1;
    dn.err = err;
    if (exp_done) done_q.push_back(dn);
  endtask

  // Starts a copy; expectations are queued before the start edge. Returns in cycle 1.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit corrupt, input bit exp_done);
    @(negedge mem_clk);
    model_copy(s, d, int'(n), corrupt, exp_done, cyc);
    src_addr_i = s;
    dst_addr_i = d;
    count_i    = n;
    start_i    = 1'b1;
    @(negedge mem_clk);
    start_i    = 1'b0;
    src_addr_i = $urandom;
    dst_addr_i = $urandom;
    count_i    = 16'($urandom);
  endtask

  // Bounded wait for the scoreboard to drain, then compare the destination words.
  task automatic drain(input string nm, input logic [31:0] d, input int n);
    int k;
    for (k = 0; k < 400; k++) begin
      if (req_q.size() == 0 && done_q.size() == 0 && !busy_o) break;
      @(negedge mem_clk);
    end
    check({nm, "_drain"}, k < 400, $sformatf("got %0d reqs %0d dones pending, required 0",
          req_q.size(), done_q.size()));
    req_q.delete();
    done_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = d + 32'(4 * i);
      if (mapped(a)) begin
        logic [31:0] got;
        got = mem.exists(a) ? mem[a] : 32'h0;
        check({nm, "_dst"}, got == ref_rd(a), $sformatf("got %h at %h, required %h", got, a, ref_rd(a)));
      end
    end
  endtask

  initial begin
    mem_reset  = 1'b1;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    count_i    = '0;
    for (int i = 0; i < 128; i++) begin
      logic [31:0] a;
      logic [31:0] v;
      a = 32'h4000_0000 + 32'(4 * i);
      v = $urandom;
      mem[a] = v;
      ref_mem[a] = v;
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h4000_0000 + 32'(4 * i);
      mem[a] = 32'(11 * (i + 1));
      ref_mem[a] = 32'(11 * (i + 1));
    end
    repeat (3) @(negedge mem_clk);
    check("rst_busy",  busy_o == 1'b0,      $sformatf("got %0b, required 0", busy_o));
    check("rst_done",  done_o == 1'b0,      $sformatf("got %0b, required 0", done_o));
    check("rst_error", error_o == 1'b0,     $sformatf("got %0b, required 0", error_o));
    check("rst_valid", mem_valid_o == 1'b0, $sformatf("got %0b, required 0", mem_valid_o));
    check("rst_read",  mem_read_o == 1'b0,  $sformatf("got %0b, required 0", mem_read_o));
    check("rst_write", mem_write_o == 1'b0, $sformatf("got %0b, required 0", mem_write_o));
    check("rst_addr",  mem_addr_o == 32'h0, $sformatf("got %h, required 0", mem_addr_o));
    check("rst_data",  mem_data_o == 32'h0, $sformatf("got %h, required 0", mem_data_o));
    check("rst_user",  mem_user_o == 32'h0, $sformatf("got %h, required 0", mem_user_o));
    mem_reset = 1'b0;

    // Normal 4-word copy: done at cycle 17, 8 requests.
    vld_cnt = 0;
    run_copy(32'h4000_0000, 32'h4000_0100, 16'd4, 1'b0, 1'b1);
    drain("normal", 32'h4000_0100, 4);
    check("normal_reqs", vld_cnt == 8, $sformatf("got %0d requests, required 8", vld_cnt));
    check("normal_word3", mem[32'h4000_010C] == 32'd44, $sformatf("got %h, required 2c", mem[32'h4000_010C]));

    // Zero count: done next cycle, no bus traffic, never busy.
    vld_cnt = 0;
    busy_cnt = 0;
    run_copy(32'h4000_0000, 32'h4000_0180, 16'd0, 1'b0, 1'b1);
    drain("count0", 32'h4000_0180, 0);
    check("count0_busy", busy_cnt == 0, $sformatf("got %0d busy cycles, required 0", busy_cnt));
    check("count0_reqs", vld_cnt == 0, $sformatf("got %0d requests, required 0", vld_cnt));

    // Unmapped destination: write times out.
    run_copy(32'h4000_0000, 32'h8000_0000, 16'd1, 1'b0, 1'b1);
    drain("timeout", 32'h8000_0000, 1);
    repeat (3) @(negedge mem_clk);
    check("error_sticky", error_o == 1'b1, $sformatf("got %0b, required 1", error_o));

    // Corrupted read tag: abort without a write.
    corrupt_rd = 1'b1;
    run_copy(32'h4000_0010, 32'h4000_0140, 16'd2, 1'b1, 1'b1);
    check("error_cleared", error_o == 1'b0, $sformatf("got %0b, required 0 after start", error_o));
    drain("tagbad", 32'h4000_0140, 2);
    corrupt_rd = 1'b0;

    // Start while busy is ignored.
    vld_cnt = 0;
    run_copy(32'h4000_0020, 32'h4000_0160, 16'd2, 1'b0, 1'b1);
    @(negedge mem_clk);
    src_addr_i = 32'h4000_0040;
    dst_addr_i = 32'h4000_01C0;
    count_i    = 16'd9;
    start_i    = 1'b1;
    @(negedge mem_clk);
    start_i    = 1'b0;
    drain("busystart", 32'h4000_0160, 2);
    check("busystart_reqs", vld_cnt == 4, $sformatf("got %0d requests, required 4", vld_cnt));

    // Reset during WR_WAIT of the second word (cycle 8).
    run_copy(32'h4000_0030, 32'h4000_01A0, 16'd2, 1'b0, 1'b0);
    repeat (7) @(negedge mem_clk);
    mem_reset = 1'b1;
    @(negedge mem_clk);
    check("midrst_busy",  busy_o == 1'b0,      $sformatf("got %0b, required 0", busy_o));
    check("midrst_done",  done_o == 1'b0,      $sformatf("got %0b, required 0", done_o));
    check("midrst_valid", mem_valid_o == 1'b0, $sformatf("got %0b, required 0", mem_valid_o));
    mem_reset = 1'b0;
    drain("midrst", 32'h4000_01A0, 2);
    run_copy(32'h4000_0000, 32'h4000_01E0, 16'd3, 1'b0, 1'b1);
    drain("afterrst", 32'h4000_01E0, 3);

    // Randomised copies, overlapping regions and occasional unmapped destinations.
    for (int it = 0; it < 10; it++) begin
      logic [31:0] s;
      logic [31:0] d;
      logic [15:0] n;
      n = 16'($urandom_range(1, 8));
      s = 32'h4000_0000 + 32'(4 * $urandom_range(0, 127));
      d = 32'h4000_0000 + 32'(4 * $urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) d = 32'h9000_0000 + 32'(4 * $urandom_range(0, 15));
      run_copy(s, d, n, 1'b0, 1'b1);
      drain("random", d, int'(n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
